// File: rtl/keypad_entry.sv
// Keypad front end: debounces the scanner's key_valid/key_code and assembles a 3-digit decimal entry.
// Build option: define KEYPAD_BACKSPACE_EN to make key D a backspace instead of command 3.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_pulse,
  output logic [3:0]  key_pulse_code,
  output logic [11:0] disp_digits,
  output logic [1:0]  digit_count,
  output logic        entry_valid,
  output logic [9:0]  entry_value,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic        overflow
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [3:0] cand;
  logic       match;
  logic       is_digit;
  logic [9:0] bcd_value;

  assign match = key_valid && (key_code == cand);

  // Scanner shares this clock, so samples are used directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      cand           <= 4'd0;
      key_pulse      <= 1'b0;
      key_pulse_code <= 4'd0;
    end else begin
      key_pulse      <= 1'b0;
      key_pulse_code <= 4'd0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            cand  <= key_code;
            cnt   <= 8'd1;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!key_valid) begin
            cnt   <= 8'd0;
            state <= IDLE;
          end else if (key_code != cand) begin
            cand <= key_code;
            cnt  <= 8'd1;
          end else if (cnt + 8'd1 == DB_LIMIT) begin
            cnt            <= 8'd0;
            state          <= HELD;
            key_pulse      <= 1'b1;
            key_pulse_code <= cand;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!match) begin
            cnt   <= 8'd1;
            state <= RELEASE_WAIT;
          end
        end
        default: begin
          if (match) begin
            cnt   <= 8'd0;
            state <= HELD;
          end else if (cnt + 8'd1 == DB_LIMIT) begin
            cnt   <= 8'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign is_digit  = (key_pulse_code <= 4'd9);
  assign bcd_value = 10'(disp_digits[11:8]) * 10'd100
                   + 10'(disp_digits[7:4])  * 10'd10
                   + 10'(disp_digits[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits <= 12'd0;
      digit_count <= 2'd0;
      entry_valid <= 1'b0;
      entry_value <= 10'd0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      cmd_valid   <= 1'b0;
      overflow    <= 1'b0;
      if (key_pulse) begin
        if (is_digit) begin
          if (digit_count != 2'd3) begin
            disp_digits <= {disp_digits[7:0], key_pulse_code};
            digit_count <= digit_count + 2'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          case (key_pulse_code)
            4'hF: begin
              if (digit_count != 2'd0) begin
                entry_value <= bcd_value;
                entry_valid <= 1'b1;
                disp_digits <= 12'd0;
                digit_count <= 2'd0;
              end
            end
            4'hE: begin
              disp_digits <= 12'd0;
              digit_count <= 2'd0;
            end
`ifdef KEYPAD_BACKSPACE_EN
            4'hD: begin
              if (digit_count != 2'd0) begin
                disp_digits <= {4'h0, disp_digits[11:4]};
                digit_count <= digit_count - 2'd1;
              end
            end
`endif
            default: begin
              // A..D are 0xA..0xD; low two bits plus 2 wrap to 0..3.
              cmd_code  <= key_pulse_code[1:0] + 2'd2;
              cmd_valid <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized bench for keypad_entry against a window/queue reference model (DEBOUNCE_CYCLES=4).
module tb_keypad_entry;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_pulse;
  logic [3:0]  key_pulse_code;
  logic [11:0] disp_digits;
  logic [1:0]  digit_count;
  logic        entry_valid;
  logic [9:0]  entry_value;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic        overflow;

  keypad_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_pulse(key_pulse), .key_pulse_code(key_pulse_code),
    .disp_digits(disp_digits), .digit_count(digit_count),
    .entry_valid(entry_valid), .entry_value(entry_value),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a sliding window of the last N samples decides press/release.
  logic [4:0] hist[$];
  bit         m_held, m_pulse, m_ev, m_cv, m_ov;
  int         m_key, m_pcode, m_val, m_cmd;
  int         dq[$];

  int cnt_key, cnt_entry, cnt_cmd, cnt_ovf, last_code;

  function automatic int disp_of();
    int d = 0;
    foreach (dq[i]) d = d * 16 + dq[i];
    return d;
  endfunction

  task automatic model_reset();
    hist.delete(); dq.delete();
    m_held = 0; m_pulse = 0; m_ev = 0; m_cv = 0; m_ov = 0;
    m_key = 0; m_pcode = 0; m_val = 0; m_cmd = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] c);
    logic [4:0] s;
    bit all;
    int k, val;
    m_ev = 0; m_cv = 0; m_ov = 0;
    if (m_pulse) begin
      k = m_pcode;
      if (k <= 9) begin
        if (dq.size() < 3) dq.push_back(k); else m_ov = 1;
      end else if (k == 15) begin
        if (dq.size() > 0) begin
          val = 0;
          foreach (dq[i]) val = val * 10 + dq[i];
          m_val = val; m_ev = 1; dq.delete();
        end
      end else if (k == 14) begin
        dq.delete();
`ifdef KEYPAD_BACKSPACE_EN
      end else if (k == 13) begin
        if (dq.size() > 0) void'(dq.pop_back());
`endif
      end else begin
        m_cmd = k - 10; m_cv = 1;
      end
    end
    m_pulse = 0;
    s = {v, c};
    hist.push_back(s);
    if (hist.size() > N) void'(hist.pop_front());
    if (hist.size() == N) begin
      all = 1;
      foreach (hist[i]) begin
        if (!m_held) all &= (hist[i] == s) && v;
        else         all &= (hist[i] != {1'b1, 4'(m_key)});
      end
      if (all) begin
        if (!m_held) begin
          m_pulse = 1; m_pcode = c; m_key = c; m_held = 1;
        end else begin
          m_held = 0;
        end
        hist.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("key_pulse", key_pulse, m_pulse);
    if (m_pulse) chk("pulse_code", key_pulse_code, m_pcode);
    chk("disp_digits", disp_digits, disp_of());
    chk("digit_count", digit_count, dq.size());
    chk("entry_valid", entry_valid, m_ev);
    chk("entry_value", entry_value, m_val);
    chk("cmd_valid", cmd_valid, m_cv);
    chk("cmd_code", cmd_code, m_cmd);
    chk("overflow", overflow, m_ov);
    chk("one_strobe", (int'(entry_valid) + int'(cmd_valid) + int'(overflow)) <= 1, 1);
  endtask

  task automatic step(input logic v, input logic [3:0] c);
    key_valid = v; key_code = c;
    @(posedge clk);
    model_edge(v, c);
    @(negedge clk);
    if (key_pulse) begin cnt_key++; last_code = key_pulse_code; end
    if (entry_valid) cnt_entry++;
    if (cmd_valid) cnt_cmd++;
    if (overflow) cnt_ovf++;
    compare_all();
  endtask

  task automatic press(input logic [3:0] c);
    repeat (N + 2) step(1'b1, c);
    repeat (N + 2) step(1'b0, 4'(c + 4'd1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_outputs", int'({key_pulse, key_pulse_code, disp_digits, digit_count, entry_valid,
                             entry_value, cmd_valid, cmd_code, overflow} != '0), 0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k0, e0, c0, o0, len;
    logic [3:0] c;
    cnt_key = 0; cnt_entry = 0; cnt_cmd = 0; cnt_ovf = 0; last_code = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single press of 5
    repeat (N) step(1'b1, 4'd5);
    chk("p5_pulse", key_pulse, 1);
    chk("p5_code", key_pulse_code, 5);
    step(1'b1, 4'd5);
    chk("p5_disp", disp_digits, 12'h005);
    chk("p5_count", digit_count, 1);
    repeat (N + 2) step(1'b0, 4'd0);
    press(4'hE);

    // 7 4 2 F
    press(4'd7); press(4'd4); press(4'd2);
    chk("742_disp", disp_digits, 12'h742);
    e0 = cnt_entry;
    press(4'hF);
    chk("742_strobes", cnt_entry - e0, 1);
    chk("742_value", entry_value, 742);
    chk("742_clear", {disp_digits, digit_count}, 0);

    // Bounce on 3 must not pulse
    k0 = cnt_key;
    repeat (3) step(1'b1, 4'd3);
    step(1'b0, 4'd3);
    repeat (3) step(1'b1, 4'd3);
    repeat (N + 2) step(1'b0, 4'd0);
    chk("bounce_no_pulse", cnt_key - k0, 0);

    // Overflow on 4th digit
    o0 = cnt_ovf;
    press(4'd1); press(4'd2); press(4'd3); press(4'd9);
    chk("ovf_strobes", cnt_ovf - o0, 1);
    chk("ovf_disp", disp_digits, 12'h123);
    press(4'hF);
    chk("ovf_value", entry_value, 123);

    // Long hold of B, then D
    c0 = cnt_cmd;
    repeat (40) step(1'b1, 4'hB);
    repeat (N + 2) step(1'b0, 4'd0);
    chk("holdB_cmds", cnt_cmd - c0, 1);
    chk("holdB_code", cmd_code, 1);
    press(4'd4); press(4'd6); press(4'hD);
`ifdef KEYPAD_BACKSPACE_EN
    chk("bksp_disp", disp_digits, 12'h004);
    chk("bksp_count", digit_count, 1);
`else
    chk("cmdD_code", cmd_code, 3);
    chk("cmdD_disp", disp_digits, 12'h046);
`endif
    press(4'hE);

    // Reset while 9 held mid-entry
    press(4'd8); press(4'd8);
    repeat (2) step(1'b1, 4'd9);
    do_reset();
    k0 = cnt_key;
    repeat (N + 4) step(1'b1, 4'd9);
    repeat (N + 2) step(1'b0, 4'd0);
    chk("rst9_pulses", cnt_key - k0, 1);
    chk("rst9_code", last_code, 9);
    chk("rst9_count", digit_count, 1);

    // Random episodes with glitches
    for (int ep = 0; ep < 150; ep++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) step($urandom_range(0, 1) == 1, 4'($urandom));
        else step(1'b1, c);
      end
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) step(1'b0, 4'($urandom));
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive identical clock samples that confirm a press or a release; legal range 2..255.
REQ-002 clk  input  1  system clock, the same clock as the keypad scanner.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key_valid  input  1  scanner output; high while a key is seen in the current frame.
REQ-005 key_code  input  4  scanner output; codes 0-9 are digits, A-D are commands, E is clear, F is enter.
REQ-006 key_pulse  output  1  one-clock strobe on each debounced press.
REQ-007 key_pulse_code  output  4  code of the press; valid while key_pulse is high.
REQ-008 disp_digits  output  12  BCD of the entry buffer: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 digit_count  output  2  number of digits in the buffer, 0..3.
REQ-010 entry_valid  output  1  one-clock strobe when a number is committed.
REQ-011 entry_value  output  10  binary value of the last committed number, 0..999; held until the next commit.
REQ-012 cmd_valid  output  1  one-clock strobe for a command key.
REQ-013 cmd_code  output  2  A=0, B=1, C=2, D=3; held until the next command.
REQ-014 overflow  output  1  one-clock strobe when a digit is rejected because the buffer is full.

Function
REQ-015 key_valid and key_code SHALL be sampled on every clk edge without extra synchronisers, because they come from the same clock domain.
REQ-016 The debouncer SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-017 IDLE: a sample with key_valid=1 SHALL load that code as the candidate, set the counter to 1 and go to PRESS_WAIT.
REQ-018 PRESS_WAIT: a sample equal to the candidate SHALL increment the counter.
REQ-019 PRESS_WAIT: a sample with key_valid=1 and a different code SHALL restart with the new candidate and counter=1.
REQ-020 PRESS_WAIT: a sample with key_valid=0 SHALL return the block to IDLE.
REQ-021 When the counter reaches DEBOUNCE_CYCLES, the block SHALL go to HELD and drive key_pulse=1 with key_pulse_code=candidate for exactly one clock.
REQ-022 HELD: any sample that does not match the candidate, including key_valid=0, SHALL set the counter to 1 and move to RELEASE_WAIT.
REQ-023 RELEASE_WAIT: a sample matching the candidate SHALL return the block to HELD.
REQ-024 RELEASE_WAIT: DEBOUNCE_CYCLES consecutive non-matching samples SHALL return the block to IDLE.
REQ-025 A held key SHALL produce exactly one key_pulse (no auto-repeat); a second key pressed while the first is held SHALL NOT pulse until a release is confirmed and the second key is re-debounced.
REQ-026 The entry logic SHALL act on the clock edge that follows key_pulse, and all its outputs SHALL be registered.
REQ-027 Digit key, digit_count<3: the digit SHALL shift in as the ones digit (older digits move up one place) and digit_count SHALL increment.
REQ-028 Digit key, digit_count=3: the buffer SHALL be left unchanged and overflow SHALL pulse.
REQ-029 Key F with digit_count>0: entry_value SHALL become hundreds*100+tens*10+ones, entry_valid SHALL pulse, and the buffer and count SHALL clear in the same cycle.
REQ-030 Key F with digit_count=0: the block SHALL take no action.
REQ-031 Key E: disp_digits and digit_count SHALL clear, with no strobe.
REQ-032 Keys A, B and C: cmd_code SHALL be set and cmd_valid SHALL pulse.
REQ-033 Key D SHALL behave as set by REQ-037 and REQ-038.
REQ-034 At most one of entry_valid, cmd_valid and overflow SHALL be high in any cycle.

Reset
REQ-035 While rst_n=0, the debouncer SHALL be in IDLE with counter and candidate at 0, and every output SHALL be 0.
REQ-036 Reset asserted mid-debounce or mid-entry SHALL discard all pending state; after reset, a key that is still held SHALL be debounced from scratch and produce one pulse.

Configuration
REQ-037 With KEYPAD_BACKSPACE_EN defined, key D SHALL act as backspace: if digit_count>0, the digits shift right one place, the top digit becomes 0 and digit_count decrements; if digit_count=0, no action is taken; cmd_valid SHALL NOT pulse.
REQ-038 With KEYPAD_BACKSPACE_EN undefined, key D SHALL set cmd_code=3 and pulse cmd_valid.

Verification (DEBOUNCE_CYCLES=4)
REQ-039 Press code 5 for 4 samples -> key_pulse=1 with code 5 for one clock; the next clock gives disp_digits=12'h005 and digit_count=1.
REQ-040 Enter codes 7, 4, 2, then F -> entry_valid pulse with entry_value=742; next cycle disp_digits=0 and digit_count=0.
REQ-041 Code 3 for 3 samples, 1 sample of key_valid=0, then code 3 for 3 samples -> no key_pulse.
REQ-042 Enter 1, 2, 3, then 9 -> overflow pulse, disp_digits stays 12'h123; then F -> entry_value=123.
REQ-043 Hold code B for 40 clocks -> exactly one cmd_valid with cmd_code=1; for D, build both ways: enter 4, 6, D -> disp_digits=12'h004 with backspace enabled, or cmd_code=3 with it disabled.
REQ-044 Enter 8, 8, assert rst_n=0 for 1 cycle while key 9 is held -> all outputs 0; after reset, exactly one key_pulse with code 9 and digit_count=1.
